// File: rtl/alu_chunked_pkg.sv
// Shared types for the chunked Hack-style ALU: control bundle, FSM states and
// the chunk-count helper.
package alu_chunked_pkg;

   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic int unsigned nch(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational CHUNK-bit ALU slice: Hack operand prep, ripple full adders or AND,
// output inversion. ALU_CHUNKED_FLAGS_EN adds the carry-into-MSB output cmsb.
module alu_slice
   import alu_chunked_pkg::*;
#(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  alu_ctrl_t        ctrl,
   input  logic             cin,
   output logic [CHUNK-1:0] r,
   output logic             cout
`ifdef ALU_CHUNKED_FLAGS_EN
   ,
   output logic             cmsb
`endif
);

   logic [CHUNK-1:0] pa, pb, sum;
   logic [CHUNK:0]   c;

   assign pa   = (ctrl.zx ? '0 : a) ^ {CHUNK{ctrl.nx}};
   assign pb   = (ctrl.zy ? '0 : b) ^ {CHUNK{ctrl.ny}};
   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]  = pa[i] ^ pb[i] ^ c[i];
      assign c[i+1]  = (pa[i] & pb[i]) | (c[i] & (pa[i] ^ pb[i]));
   end

   // Carries are gated by f so the AND path never leaks a carry into the next chunk.
   assign r    = (ctrl.f ? sum : (pa & pb)) ^ {CHUNK{ctrl.no}};
   assign cout = ctrl.f & c[CHUNK];
`ifdef ALU_CHUNKED_FLAGS_EN
   assign cmsb = ctrl.f & c[CHUNK-1];
`endif

endmodule

// File: rtl/alu_chunked.sv
// Multi-cycle Hack-style ALU computing CHUNK bits per clock, LSB first, with
// valid/ready on both sides. Optional co/ov flag ports: ALU_CHUNKED_FLAGS_EN.
module alu_chunked
   import alu_chunked_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             zr,
   output logic             ng
`ifdef ALU_CHUNKED_FLAGS_EN
   ,
   output logic             co,
   output logic             ov
`endif
);

   localparam int unsigned   NCH  = nch(WIDTH, CHUNK);
   localparam int unsigned   CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("alu_chunked: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state_q, state_d;
   alu_ctrl_t        ctrl_q;
   logic [WIDTH-1:0] x_q, y_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, nz_q;
   logic [CHUNK-1:0] r;
   logic             cout;
   logic             accept, last;
`ifdef ALU_CHUNKED_FLAGS_EN
   logic             cmsb;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (state_q == BUSY) && (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)     state_d = BUSY;
         BUSY:    if (cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operands shift right each chunk so the slice always sees the low CHUNK bits.
   alu_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (x_q[CHUNK-1:0]),
      .b    (y_q[CHUNK-1:0]),
      .ctrl (ctrl_q),
      .cin  (carry_q),
      .r    (r),
      .cout (cout)
`ifdef ALU_CHUNKED_FLAGS_EN
      ,
      .cmsb (cmsb)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         nz_q    <= 1'b0;
         o       <= '0;
         zr      <= 1'b0;
         ng      <= 1'b0;
`ifdef ALU_CHUNKED_FLAGS_EN
         co      <= 1'b0;
         ov      <= 1'b0;
`endif
      end else if (accept) begin
         x_q     <= x;
         y_q     <= y;
         ctrl_q  <= {zx, nx, zy, ny, f, no};
         cnt_q   <= '0;
         carry_q <= 1'b0;
         nz_q    <= 1'b0;
      end else if (state_q == BUSY) begin
         x_q                          <= x_q >> CHUNK;
         y_q                          <= y_q >> CHUNK;
         carry_q                      <= cout;
         nz_q                         <= nz_q | (|r);
         o[int'(cnt_q)*CHUNK +: CHUNK] <= r;
         cnt_q                        <= last ? '0 : cnt_q + CW'(1);
         if (last) begin
            zr <= ~(nz_q | (|r));
            ng <= r[CHUNK-1];
`ifdef ALU_CHUNKED_FLAGS_EN
            co <= cout;
            ov <= cmsb ^ cout;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_chunked.sv
// Self-checking bench for alu_chunked: directed and random ops on a 16/4 instance,
// random sweeps on 16/1, 16/16 and 32/4 instances against an arithmetic model.
module tb_alu_chunked;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   typedef struct packed {
      logic [63:0] o;
      logic        zr;
      logic        ng;
      logic        co;
      logic        ov;
   } res_t;

   // c = {zx,nx,zy,ny,f,no}; arithmetic on w-bit values held in 64-bit words
   function automatic res_t model(input logic [63:0] xv, input logic [63:0] yv,
                                  input logic [5:0] c, input int w);
      logic [63:0] mask, a, b, s;
      logic [64:0] full;
      res_t        rr;
      mask = (64'd1 << w) - 64'd1;
      a = c[5] ? 64'd0 : xv;
      if (c[4]) a = ~a;
      a = a & mask;
      b = c[3] ? 64'd0 : yv;
      if (c[2]) b = ~b;
      b = b & mask;
      rr = '0;
      if (c[1]) begin
         full  = {1'b0, a} + {1'b0, b};
         s     = full[63:0] & mask;
         rr.co = full[w];
         rr.ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      end else begin
         s = a & b;
      end
      if (c[0]) s = ~s & mask;
      rr.o  = s;
      rr.zr = (s == 64'd0);
      rr.ng = s[w-1];
      return rr;
   endfunction

   // ---------------- main instance, WIDTH=16 CHUNK=4 ----------------
   logic        rst_n, m_iv, m_ir, m_ov, m_ordy, m_zr, m_ng;
   logic [15:0] m_x, m_y, m_o;
   logic [5:0]  m_c;
`ifdef ALU_CHUNKED_FLAGS_EN
   logic        m_co, m_ovf;
`endif

   alu_chunked #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (m_iv),
      .in_ready  (m_ir),
      .x         (m_x),
      .y         (m_y),
      .zx        (m_c[5]),
      .nx        (m_c[4]),
      .zy        (m_c[3]),
      .ny        (m_c[2]),
      .f         (m_c[1]),
      .no        (m_c[0]),
      .out_valid (m_ov),
      .out_ready (m_ordy),
      .o         (m_o),
      .zr        (m_zr),
      .ng        (m_ng)
`ifdef ALU_CHUNKED_FLAGS_EN
      ,
      .co        (m_co),
      .ov        (m_ovf)
`endif
   );

   task automatic m_issue(input logic [15:0] xv, input logic [15:0] yv,
                          input logic [5:0] cv, output int lat);
      int w;
      w = 0;
      while (!m_ir && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check("issue.in_ready", m_ir, 1);
      m_x = xv; m_y = yv; m_c = cv; m_iv = 1'b1;
      @(posedge clk); #1;
      // scramble inputs after accept: the op must use the latched values
      m_iv = 1'b0; m_x = 16'($urandom); m_y = 16'($urandom); m_c = 6'($urandom);
      lat = 0;
      while (!m_ov && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic m_drain();
      m_ordy = 1'b1;
      @(posedge clk); #1;
      m_ordy = 1'b0;
      check("drain.out_valid", m_ov, 0);
   endtask

   task automatic m_op(input logic [15:0] xv, input logic [15:0] yv,
                       input logic [5:0] cv, input string tag);
      int   lat;
      res_t ex;
      ex = model(64'(xv), 64'(yv), cv, 16);
      m_issue(xv, yv, cv, lat);
      check({tag, ".lat"}, lat, 4);
      check({tag, ".o"}, m_o, ex.o);
      check({tag, ".zr"}, m_zr, ex.zr);
      check({tag, ".ng"}, m_ng, ex.ng);
`ifdef ALU_CHUNKED_FLAGS_EN
      check({tag, ".co"}, m_co, ex.co);
      check({tag, ".ov"}, m_ovf, ex.ov);
`endif
      repeat ($urandom_range(0, 3)) begin
         @(posedge clk); #1;
         check({tag, ".hold_o"}, m_o, ex.o);
      end
      m_drain();
   endtask

   // ---------------- sweep instances ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W   = (g == 2) ? 32 : 16;
      localparam int C   = (g == 0) ? 1 : ((g == 1) ? 16 : 4);
      localparam int NCH = W / C;

      logic         s_rst, s_iv, s_ir, s_ov, s_ordy, s_zr, s_ng;
      logic [W-1:0] s_x, s_y, s_o;
      logic [5:0]   s_c;
      logic         done = 1'b0;
`ifdef ALU_CHUNKED_FLAGS_EN
      logic         s_co, s_ovf;
`endif

      alu_chunked #(.WIDTH(W), .CHUNK(C)) u_sw (
         .clk       (clk),
         .rst_n     (s_rst),
         .in_valid  (s_iv),
         .in_ready  (s_ir),
         .x         (s_x),
         .y         (s_y),
         .zx        (s_c[5]),
         .nx        (s_c[4]),
         .zy        (s_c[3]),
         .ny        (s_c[2]),
         .f         (s_c[1]),
         .no        (s_c[0]),
         .out_valid (s_ov),
         .out_ready (s_ordy),
         .o         (s_o),
         .zr        (s_zr),
         .ng        (s_ng)
`ifdef ALU_CHUNKED_FLAGS_EN
         ,
         .co        (s_co),
         .ov        (s_ovf)
`endif
      );

      initial begin
         logic [63:0] xr, yr;
         res_t        ex;
         int          lat;
         s_rst = 1'b1; s_iv = 1'b0; s_ordy = 1'b0; s_x = '0; s_y = '0; s_c = '0;
         #1 s_rst = 1'b0;
         repeat (2) @(posedge clk);
         #1 s_rst = 1'b1;
         for (int i = 0; i < 25; i++) begin
            xr = {$urandom, $urandom};
            yr = {$urandom, $urandom};
            s_c = 6'($urandom);
            s_x = xr[W-1:0];
            s_y = yr[W-1:0];
            ex = model(xr, yr, s_c, W);
            check($sformatf("sw%0d.in_ready", g), s_ir, 1);
            s_iv = 1'b1;
            @(posedge clk); #1;
            s_iv = 1'b0; s_x = '1; s_y = '0; s_c = 6'($urandom);
            lat = 0;
            while (!s_ov && lat < 100) begin
               @(posedge clk); #1;
               lat++;
            end
            check($sformatf("sw%0d.lat", g), lat, NCH);
            check($sformatf("sw%0d.o", g), s_o, ex.o);
            check($sformatf("sw%0d.zr", g), s_zr, ex.zr);
            check($sformatf("sw%0d.ng", g), s_ng, ex.ng);
`ifdef ALU_CHUNKED_FLAGS_EN
            check($sformatf("sw%0d.co", g), s_co, ex.co);
            check($sformatf("sw%0d.ov", g), s_ovf, ex.ov);
`endif
            s_ordy = 1'b1;
            @(posedge clk); #1;
            s_ordy = 1'b0;
         end
         done = 1'b1;
      end
   end

   // ---------------- directed sequence on the main instance ----------------
   initial begin
      int lat;
      int t;
      rst_n = 1'b1; m_iv = 1'b0; m_ordy = 1'b0; m_x = '0; m_y = '0; m_c = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", m_ov, 0);
      check("rst.in_ready", m_ir, 1);
      check("rst.o", m_o, 0);
      check("rst.zr", m_zr, 0);
      check("rst.ng", m_ng, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      m_issue(16'd5, 16'd3, 6'b000010, lat);
      check("add.lat", lat, 4);
      check("add.o", m_o, 16'h0008);
      check("add.zr", m_zr, 0);
      check("add.ng", m_ng, 0);
      m_drain();

      m_issue(16'd3, 16'd5, 6'b010011, lat);
      check("sub.o", m_o, 16'hFFFE);
      check("sub.ng", m_ng, 1);
      check("sub.zr", m_zr, 0);
      m_drain();

      m_issue(16'h1234, 16'hABCD, 6'b101010, lat);
      check("zero.o", m_o, 16'h0000);
      check("zero.zr", m_zr, 1);
      check("zero.ng", m_ng, 0);
      m_drain();

      m_issue(16'h1234, 16'hABCD, 6'b111010, lat);
      check("neg1.o", m_o, 16'hFFFF);
      check("neg1.ng", m_ng, 1);
      check("neg1.zr", m_zr, 0);
      m_drain();

`ifdef ALU_CHUNKED_FLAGS_EN
      m_issue(16'h7FFF, 16'h0001, 6'b000010, lat);
      check("ovf.o", m_o, 16'h8000);
      check("ovf.ov", m_ovf, 1);
      check("ovf.co", m_co, 0);
      m_drain();
      m_issue(16'hFFFF, 16'h0001, 6'b000010, lat);
      check("cry.o", m_o, 16'h0000);
      check("cry.co", m_co, 1);
      check("cry.ov", m_ovf, 0);
      m_drain();
`endif

      // backpressure with a new request already waiting
      m_issue(16'h1234, 16'h0F0F, 6'b000010, lat);
      check("bp.o0", m_o, 16'h2143);
      m_x = 16'h0042; m_y = 16'h0001; m_c = 6'b000010; m_iv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp.o", m_o, 16'h2143);
         check("bp.out_valid", m_ov, 1);
         check("bp.in_ready", m_ir, 0);
      end
      m_ordy = 1'b1;
      @(posedge clk); #1;
      m_ordy = 1'b0;
      check("bp.released_valid", m_ov, 0);
      check("bp.released_ready", m_ir, 1);
      @(posedge clk); #1;
      m_iv = 1'b0; m_x = 16'hDEAD; m_y = 16'hBEEF;
      check("bp.accepted", m_ir, 0);
      lat = 0;
      while (!m_ov && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp.lat", lat, 4);
      check("bp.o1", m_o, 16'h0043);
      m_drain();

      // reset while chunk 2 is in flight
      m_x = 16'h5555; m_y = 16'h0000; m_c = 6'b111010; m_iv = 1'b1;
      @(posedge clk); #1;
      m_iv = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", m_ov, 0);
      check("midrst.o", m_o, 0);
      check("midrst.in_ready", m_ir, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst.no_result", m_ov, 0);
      m_op(16'h00F0, 16'h0F0F, 6'b000010, "postrst");

      for (int i = 0; i < 30; i++) begin
         m_op(16'($urandom), 16'($urandom), 6'($urandom), $sformatf("rnd%0d", i));
      end

      t = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      check("sweep.finished", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
